// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO: fixed-latency MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Define MDU_MADD_EN to also accept MADD/MADDU/MSUB/MSUBU (md_op 8-11) as multiply-class ops.
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        md_start,
   input  logic [3:0]  md_op,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   output logic        md_busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MTHI  = 4'd4,
      OP_MTLO  = 4'd5,
      OP_MADD  = 4'd8,
      OP_MADDU = 4'd9,
      OP_MSUB  = 4'd10,
      OP_MSUBU = 4'd11
   } mdOpT;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } stateT;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   function automatic logic isMulOp(input logic [3:0] op);
      logic r;
      r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
      r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return r;
   endfunction

   function automatic logic isDivOp(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic isLongOp(input logic [3:0] op);
      return isMulOp(op) || isDivOp(op);
   endfunction

   stateT            state, stateNext;
   logic [CNT_W-1:0] count, countNext;
   logic [3:0]       opReg;
   logic [31:0]      aReg, bReg;
   logic [31:0]      hiNext, loNext;
   logic             loadOps;

   // Combinational in the start cycle so the hazard unit stalls the following MD op at once.
   assign md_busy = (state == BUSY) || (md_start && isLongOp(md_op));

   // One 64x64 multiplier serves signed and unsigned: the low 64 bits of the product are exact
   // once the operands are extended according to signedness.
   logic        mulSigned;
   logic [63:0] mulA, mulB, product;

`ifdef MDU_MADD_EN
   assign mulSigned = (opReg == OP_MULT) || (opReg == OP_MADD) || (opReg == OP_MSUB);
`else
   assign mulSigned = (opReg == OP_MULT);
`endif
   assign mulA    = mulSigned ? {{32{aReg[31]}}, aReg} : {32'd0, aReg};
   assign mulB    = mulSigned ? {{32{bReg[31]}}, bReg} : {32'd0, bReg};
   assign product = mulA * mulB;

   // Signed division on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0 naturally.
   logic        divSigned, aNeg, bNeg, divByZero;
   logic [31:0] aMag, bMag, bSafe, qMag, rMag, quotient, remainder;

   assign divSigned = (opReg == OP_DIV);
   assign aNeg      = divSigned && aReg[31];
   assign bNeg      = divSigned && bReg[31];
   assign aMag      = aNeg ? (32'd0 - aReg) : aReg;
   assign bMag      = bNeg ? (32'd0 - bReg) : bReg;
   assign divByZero = (bReg == 32'd0);
   assign bSafe     = divByZero ? 32'd1 : bMag;
   assign qMag      = aMag / bSafe;
   assign rMag      = aMag % bSafe;
   assign quotient  = (aNeg ^ bNeg) ? (32'd0 - qMag) : qMag;
   assign remainder = aNeg ? (32'd0 - rMag) : rMag;

`ifdef MDU_MADD_EN
   // Accumulates onto HI/LO as they stand at completion, not as they were at start.
   logic [63:0] accResult;
   assign accResult = ((opReg == OP_MSUB) || (opReg == OP_MSUBU)) ? ({hi, lo} - product)
                                                                  : ({hi, lo} + product);
`endif

   always_comb begin
      // NOTE: every signal written here is defaulted first so no path leaves it unassigned and infers a latch.
      stateNext = state;
      countNext = count;
      hiNext    = hi;
      loNext    = lo;
      loadOps   = 1'b0;
      case (state)
         IDLE: begin
            if (md_start) begin
               if (isLongOp(md_op)) begin
                  stateNext = BUSY;
                  loadOps   = 1'b1;
                  countNext = isDivOp(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
               end else if (md_op == OP_MTHI) begin
                  hiNext = md_a;
               end else if (md_op == OP_MTLO) begin
                  loNext = md_a;
               end
            end
         end
         BUSY: begin
            // Inputs are ignored here: a start while busy neither restarts nor writes HI/LO.
            if (count == '0) begin
               stateNext = IDLE;
               case (opReg)
                  OP_MULT, OP_MULTU: {hiNext, loNext} = product;
                  OP_DIV, OP_DIVU: begin
                     if (!divByZero) begin
                        loNext = quotient;
                        hiNext = remainder;
                     end
                  end
`ifdef MDU_MADD_EN
                  OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: {hiNext, loNext} = accResult;
`endif
                  default: ;
               endcase
            end else begin
               countNext = count - CNT_W'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: latched operands are reset too, so the datapath never carries X after reset.
         state <= IDLE;
         count <= '0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         opReg <= 4'd0;
         aReg  <= 32'd0;
         bReg  <= 32'd0;
      end else begin
         state <= stateNext;
         count <= countNext;
         hi    <= hiNext;
         lo    <= loNext;
         if (loadOps) begin
            opReg <= md_op;
            aReg  <= md_a;
            bReg  <= md_b;
         end
      end
   end

endmodule
